// File: rtl/op_tx_pkg.sv
// op_tx_pkg: query-state codes, switch FSM states and counter sizing shared by the Tx switch
package op_tx_pkg;
  localparam logic [2:0] OP_SCAN = 3'd0;
  localparam logic [2:0] OP_JOIN = 3'd1;
  localparam logic [2:0] OP_DONE = 3'd5;
  typedef enum logic [1:0] {RUN, DRAIN, SWITCH} t_sw_state;
  function automatic int ctr_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction
endpackage

// File: rtl/op_tx_switch_if.sv
// op_tx_switch_if: operator/MPF request bus of the Tx switch; slave = switch side, master = environment side
interface op_tx_switch_if #(
  parameter int N_OPS   = 2,
  parameter int ADDR_W  = 42,
  parameter int DATA_W  = 512,
  parameter int MDATA_W = 16
);
  logic                       state_wr_en;
  logic [2:0]                 state_wr_data;
  logic                       c0TxAlmFull;
  logic                       c1TxAlmFull;
  logic                       c0NotEmpty;
  logic                       c1NotEmpty;
  logic                       rd_rsp_valid;
  logic                       wr_rsp_valid;
  logic [N_OPS-1:0]           op_rd_valid;
  logic [N_OPS*ADDR_W-1:0]    op_rd_addr;
  logic [N_OPS*MDATA_W-1:0]   op_rd_mdata;
  logic [N_OPS-1:0]           op_wr_valid;
  logic [N_OPS*ADDR_W-1:0]    op_wr_addr;
  logic [N_OPS*DATA_W-1:0]    op_wr_data;
  logic [N_OPS*MDATA_W-1:0]   op_wr_mdata;
  logic [N_OPS-1:0]           op_active;
  logic                       op_rd_ready;
  logic                       op_wr_ready;
  logic                       rd_valid;
  logic [ADDR_W-1:0]          rd_addr;
  logic [MDATA_W-1:0]         rd_mdata;
  logic                       wr_valid;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic [MDATA_W-1:0]         wr_mdata;
  logic [2:0]                 cur_state;
  logic                       switching;
  logic                       query_done;
  logic                       cnt_err;
  modport slave (
    input  state_wr_en, state_wr_data, c0TxAlmFull, c1TxAlmFull, c0NotEmpty, c1NotEmpty,
           rd_rsp_valid, wr_rsp_valid, op_rd_valid, op_rd_addr, op_rd_mdata,
           op_wr_valid, op_wr_addr, op_wr_data, op_wr_mdata,
    output op_active, op_rd_ready, op_wr_ready, rd_valid, rd_addr, rd_mdata,
           wr_valid, wr_addr, wr_data, wr_mdata, cur_state, switching, query_done, cnt_err
  );
  modport master (
    output state_wr_en, state_wr_data, c0TxAlmFull, c1TxAlmFull, c0NotEmpty, c1NotEmpty,
           rd_rsp_valid, wr_rsp_valid, op_rd_valid, op_rd_addr, op_rd_mdata,
           op_wr_valid, op_wr_addr, op_wr_data, op_wr_mdata,
    input  op_active, op_rd_ready, op_wr_ready, rd_valid, rd_addr, rd_mdata,
           wr_valid, wr_addr, wr_data, wr_mdata, cur_state, switching, query_done, cnt_err
  );
endinterface

// File: rtl/req_outstanding_ctr.sv
// req_outstanding_ctr: outstanding-request up/down counter (i_inc issue, i_dec response; o_cnt, o_at_max, sticky o_err on underflow)
module req_outstanding_ctr #(
  parameter int MAX_OUT = 256,
  parameter int CW      = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [CW-1:0] o_cnt,
  output logic          o_at_max,
  output logic          o_err
);
  logic [CW-1:0] r_cnt;
  logic          r_err;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (i_inc && !i_dec && !o_at_max) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (i_dec && !i_inc) begin
      if (r_cnt == '0) r_err <= 1'b1;
      else r_cnt <= r_cnt - 1'b1;
    end
  end
  assign o_cnt    = r_cnt;
  assign o_at_max = r_cnt == CW'(MAX_OUT);
  assign o_err    = r_err;
endmodule

// File: rtl/op_tx_switch.sv
// op_tx_switch: drained, registered operator-to-MPF Tx request switch (clk, async active-low reset, bus = op_tx_switch_if.slave)
module op_tx_switch
  import op_tx_pkg::*;
#(
  parameter int N_OPS   = 2,
  parameter int ADDR_W  = 42,
  parameter int DATA_W  = 512,
  parameter int MDATA_W = 16,
  parameter int MAX_OUT = 256
) (
  input logic           clk,
  input logic           reset,
  op_tx_switch_if.slave bus
);
  localparam int CW = ctr_w(MAX_OUT);
  t_sw_state          r_state, w_state_n;
  logic [2:0]         r_cur_state, w_cur_n, r_pending, w_pending_n;
  logic [CW-1:0]      w_rd_cnt, w_wr_cnt;
  logic               w_rd_max, w_wr_max, w_rd_err, w_wr_err;
  logic [N_OPS-1:0]   w_active;
  logic               w_rd_v, w_wr_v, w_rd_rdy, w_wr_rdy, w_rd_acc, w_wr_acc, w_drained;
  logic [ADDR_W-1:0]  w_rd_addr, w_wr_addr, r_rd_addr, r_wr_addr;
  logic [MDATA_W-1:0] w_rd_mdata, w_wr_mdata, r_rd_mdata, r_wr_mdata;
  logic [DATA_W-1:0]  w_wr_data, r_wr_data;
  logic               r_rd_valid, r_wr_valid;
  always_comb begin
    w_active   = '0;
    w_rd_v     = 1'b0;
    w_rd_addr  = '0;
    w_rd_mdata = '0;
    w_wr_v     = 1'b0;
    w_wr_addr  = '0;
    w_wr_data  = '0;
    w_wr_mdata = '0;
    for (int i = 0; i < N_OPS; i++) begin
      w_active[i] = r_cur_state == 3'(i);
      if (w_active[i]) begin
        w_rd_v     = bus.op_rd_valid[i];
        w_rd_addr  = bus.op_rd_addr[i*ADDR_W +: ADDR_W];
        w_rd_mdata = bus.op_rd_mdata[i*MDATA_W +: MDATA_W];
        w_wr_v     = bus.op_wr_valid[i];
        w_wr_addr  = bus.op_wr_addr[i*ADDR_W +: ADDR_W];
        w_wr_data  = bus.op_wr_data[i*DATA_W +: DATA_W];
        w_wr_mdata = bus.op_wr_mdata[i*MDATA_W +: MDATA_W];
      end
    end
  end
  // ready is held low while reset is asserted so nothing is granted before the stage is live
  assign w_rd_rdy  = reset && r_state == RUN && |w_active && !bus.c0TxAlmFull && !w_rd_max;
  assign w_wr_rdy  = reset && r_state == RUN && |w_active && !bus.c1TxAlmFull && !w_wr_max;
  assign w_rd_acc  = w_rd_v && w_rd_rdy;
  assign w_wr_acc  = w_wr_v && w_wr_rdy;
  assign w_drained = w_rd_cnt == '0 && w_wr_cnt == '0 && !bus.c0NotEmpty && !bus.c1NotEmpty;
  always_comb begin
    w_pending_n = bus.state_wr_en ? bus.state_wr_data : r_pending;
    w_state_n   = r_state == RUN   ? (bus.state_wr_en ? DRAIN : RUN) :
                  r_state == DRAIN ? (w_drained ? SWITCH : DRAIN) : RUN;
    w_cur_n     = r_state == SWITCH ? w_pending_n : r_cur_state;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= RUN;
      r_cur_state <= OP_SCAN;
      r_pending   <= OP_SCAN;
      r_rd_valid  <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_mdata  <= '0;
      r_wr_valid  <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_wr_mdata  <= '0;
    end else begin
      r_state     <= w_state_n;
      r_cur_state <= w_cur_n;
      r_pending   <= w_pending_n;
      r_rd_valid  <= w_rd_acc;
      r_wr_valid  <= w_wr_acc;
      if (w_rd_acc) begin
        r_rd_addr  <= w_rd_addr;
        r_rd_mdata <= w_rd_mdata;
      end
      if (w_wr_acc) begin
        r_wr_addr  <= w_wr_addr;
        r_wr_data  <= w_wr_data;
        r_wr_mdata <= w_wr_mdata;
      end
    end
  end
  req_outstanding_ctr #(.MAX_OUT(MAX_OUT), .CW(CW)) u_rd_ctr (
    .clk(clk), .reset(reset), .i_inc(w_rd_acc), .i_dec(bus.rd_rsp_valid),
    .o_cnt(w_rd_cnt), .o_at_max(w_rd_max), .o_err(w_rd_err)
  );
  req_outstanding_ctr #(.MAX_OUT(MAX_OUT), .CW(CW)) u_wr_ctr (
    .clk(clk), .reset(reset), .i_inc(w_wr_acc), .i_dec(bus.wr_rsp_valid),
    .o_cnt(w_wr_cnt), .o_at_max(w_wr_max), .o_err(w_wr_err)
  );
  assign bus.op_active   = w_active;
  assign bus.op_rd_ready = w_rd_rdy;
  assign bus.op_wr_ready = w_wr_rdy;
  assign bus.rd_valid    = r_rd_valid;
  assign bus.rd_addr     = r_rd_addr;
  assign bus.rd_mdata    = r_rd_mdata;
  assign bus.wr_valid    = r_wr_valid;
  assign bus.wr_addr     = r_wr_addr;
  assign bus.wr_data     = r_wr_data;
  assign bus.wr_mdata    = r_wr_mdata;
  assign bus.cur_state   = r_cur_state;
  assign bus.switching   = r_state != RUN;
  assign bus.query_done  = r_cur_state == OP_DONE;
  assign bus.cnt_err     = w_rd_err | w_wr_err;
endmodule

// File: tb/tb_op_tx_switch.sv
// tb_op_tx_switch: directed self-checking bench for op_tx_switch
module tb_op_tx_switch;
  import op_tx_pkg::*;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;
  op_tx_switch_if bus ();
  op_tx_switch dut (.clk(clk), .reset(reset), .bus(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask
  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b0;
    bus.state_wr_en   = 1'b0;
    bus.state_wr_data = 3'd0;
    bus.c0TxAlmFull   = 1'b0;
    bus.c1TxAlmFull   = 1'b0;
    bus.c0NotEmpty    = 1'b0;
    bus.c1NotEmpty    = 1'b0;
    bus.rd_rsp_valid  = 1'b0;
    bus.wr_rsp_valid  = 1'b0;
    bus.op_rd_valid   = 2'b01;
    bus.op_rd_addr    = '0;
    bus.op_rd_mdata   = '0;
    bus.op_wr_valid   = 2'b00;
    bus.op_wr_addr    = '0;
    bus.op_wr_data    = '0;
    bus.op_wr_mdata   = '0;
    bus.op_rd_addr[0 +: 42]  = 42'h100;
    bus.op_rd_mdata[0 +: 16] = 16'h0011;
    #1;
    chk("rst_active", bus.op_active, 2'b01);
    chk("rst_cur", bus.cur_state, 3'd0);
    chk("rst_rd_valid", bus.rd_valid, 1'b0);
    chk("rst_wr_valid", bus.wr_valid, 1'b0);
    chk("rst_rd_ready", bus.op_rd_ready, 1'b0);
    chk("rst_switching", bus.switching, 1'b0);
    chk("rst_query_done", bus.query_done, 1'b0);
    chk("rst_cnt_err", bus.cnt_err, 1'b0);
    chk("rst_rd_addr", bus.rd_addr, 42'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rel_rd_ready", bus.op_rd_ready, 1'b1);
    step();
    bus.op_rd_valid = 2'b00;
    chk("first_rd_valid", bus.rd_valid, 1'b1);
    chk("first_rd_addr", bus.rd_addr, 42'h100);
    chk("first_rd_mdata", bus.rd_mdata, 16'h0011);
    chk("first_rd_cnt", dut.w_rd_cnt, 9'd1);
    bus.rd_rsp_valid = 1'b1;
    step();
    bus.rd_rsp_valid = 1'b0;
    chk("rsp_rd_cnt", dut.w_rd_cnt, 9'd0);
    chk("hold_rd_valid", bus.rd_valid, 1'b0);
    chk("hold_rd_addr", bus.rd_addr, 42'h100);
    bus.c0TxAlmFull = 1'b1;
    bus.op_rd_valid = 2'b01;
    bus.op_rd_addr[0 +: 42] = 42'h200;
    #1;
    chk("almfull_ready", bus.op_rd_ready, 1'b0);
    chk("almfull_wr_ready", bus.op_wr_ready, 1'b1);
    step();
    chk("almfull_no_valid", bus.rd_valid, 1'b0);
    chk("almfull_cnt", dut.w_rd_cnt, 9'd0);
    bus.c0TxAlmFull = 1'b0;
    #1;
    chk("almfree_ready", bus.op_rd_ready, 1'b1);
    step();
    chk("almfree_valid", bus.rd_valid, 1'b1);
    chk("almfree_addr", bus.rd_addr, 42'h200);
    bus.op_rd_addr[0 +: 42] = 42'h300;
    step();
    chk("two_cnt", dut.w_rd_cnt, 9'd2);
    bus.rd_rsp_valid = 1'b1;
    step();
    chk("same_cycle_cnt", dut.w_rd_cnt, 9'd2);
    chk("same_cycle_valid", bus.rd_valid, 1'b1);
    bus.op_rd_valid = 2'b00;
    repeat (2) step();
    bus.rd_rsp_valid = 1'b0;
    chk("drained_cnt", dut.w_rd_cnt, 9'd0);
    bus.op_rd_valid = 2'b01;
    repeat (3) step();
    bus.op_rd_valid = 2'b00;
    chk("three_cnt", dut.w_rd_cnt, 9'd3);
    bus.c0NotEmpty    = 1'b1;
    bus.state_wr_en   = 1'b1;
    bus.state_wr_data = OP_JOIN;
    step();
    bus.state_wr_en = 1'b0;
    chk("drain_state", dut.r_state, DRAIN);
    chk("drain_switching", bus.switching, 1'b1);
    chk("drain_rd_ready", bus.op_rd_ready, 1'b0);
    chk("drain_wr_ready", bus.op_wr_ready, 1'b0);
    chk("drain_active", bus.op_active, 2'b01);
    bus.rd_rsp_valid = 1'b1;
    repeat (3) step();
    bus.rd_rsp_valid = 1'b0;
    chk("drain_cnt0", dut.w_rd_cnt, 9'd0);
    step();
    chk("drain_wait_ne", dut.r_state, DRAIN);
    chk("drain_wait_active", bus.op_active, 2'b01);
    bus.c0NotEmpty = 1'b0;
    step();
    chk("switch_state", dut.r_state, SWITCH);
    chk("switch_switching", bus.switching, 1'b1);
    chk("switch_active", bus.op_active, 2'b01);
    step();
    chk("join_state", dut.r_state, RUN);
    chk("join_cur", bus.cur_state, 3'd1);
    chk("join_active", bus.op_active, 2'b10);
    chk("join_switching", bus.switching, 1'b0);
    chk("join_rd_ready", bus.op_rd_ready, 1'b1);
    bus.op_wr_valid = 2'b11;
    bus.op_wr_addr[0 +: 42]   = 42'h0AA;
    bus.op_wr_addr[42 +: 42]  = 42'h555;
    bus.op_wr_data[0 +: 64]   = 64'h1111;
    bus.op_wr_data[512 +: 64] = 64'hABCD_0123;
    bus.op_wr_mdata[16 +: 16] = 16'h0007;
    step();
    bus.op_wr_valid = 2'b00;
    chk("join_wr_valid", bus.wr_valid, 1'b1);
    chk("join_wr_addr", bus.wr_addr, 42'h555);
    chk("join_wr_data", bus.wr_data[63:0], 64'hABCD_0123);
    chk("join_wr_mdata", bus.wr_mdata, 16'h0007);
    chk("join_wr_cnt", dut.w_wr_cnt, 9'd1);
    chk("join_rd_none", bus.rd_valid, 1'b0);
    bus.wr_rsp_valid = 1'b1;
    step();
    bus.wr_rsp_valid = 1'b0;
    chk("join_wr_cnt0", dut.w_wr_cnt, 9'd0);
    bus.c1NotEmpty    = 1'b1;
    bus.state_wr_en   = 1'b1;
    bus.state_wr_data = OP_JOIN;
    step();
    bus.state_wr_data = OP_DONE;
    step();
    bus.state_wr_en = 1'b0;
    bus.c1NotEmpty  = 1'b0;
    chk("lww_still_drain", dut.r_state, DRAIN);
    chk("lww_cur_old", bus.cur_state, 3'd1);
    repeat (2) step();
    chk("done_cur", bus.cur_state, 3'd5);
    chk("done_flag", bus.query_done, 1'b1);
    chk("done_active", bus.op_active, 2'b00);
    chk("done_rd_ready", bus.op_rd_ready, 1'b0);
    chk("done_wr_ready", bus.op_wr_ready, 1'b0);
    bus.rd_rsp_valid = 1'b1;
    step();
    bus.rd_rsp_valid = 1'b0;
    chk("uf_err", bus.cnt_err, 1'b1);
    chk("uf_cnt", dut.w_rd_cnt, 9'd0);
    repeat (2) step();
    chk("uf_sticky", bus.cnt_err, 1'b1);
    bus.c0NotEmpty    = 1'b1;
    bus.state_wr_en   = 1'b1;
    bus.state_wr_data = OP_JOIN;
    step();
    bus.state_wr_en = 1'b0;
    chk("mid_drain", dut.r_state, DRAIN);
    #3 reset = 1'b0;
    #1;
    chk("arst_state", dut.r_state, RUN);
    chk("arst_cur", bus.cur_state, 3'd0);
    chk("arst_rd_cnt", dut.w_rd_cnt, 9'd0);
    chk("arst_wr_cnt", dut.w_wr_cnt, 9'd0);
    chk("arst_err", bus.cnt_err, 1'b0);
    chk("arst_active", bus.op_active, 2'b01);
    chk("arst_switching", bus.switching, 1'b0);
    bus.c0NotEmpty = 1'b0;
    step();
    reset = 1'b1;
    repeat (3) step();
    chk("post_state", dut.r_state, RUN);
    chk("post_cur", bus.cur_state, 3'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/op_tx_switch.md
Name: op_tx_switch

Overview:
- Request-side stage between the operator units (scan = 0, join = 1) and the MPF Tx channels.
- Replaces the combinational query-state mux with a drained, registered switch.
- Tracks outstanding reads and writes per channel; blocks the next operator until MPF and the counters are empty.
- Drives each unit's is_active and per-channel ready, and flags query completion.

Parameters:
- N_OPS, 2, number of operator units; unit id = index.
- ADDR_W, 42, CCI-P line address width.
- DATA_W, 512, write data width.
- MDATA_W, 16, request metadata width.
- MAX_OUT, 256, outstanding-request cap per channel; counter width = $clog2(MAX_OUT+1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- state_wr_en  in  1  CSR[7] write strobe
- state_wr_data  in  3  new query state: 0 scan, 1 join, 5 query_done
- c0TxAlmFull  in  1  read channel almost full
- c1TxAlmFull  in  1  write channel almost full
- c0NotEmpty  in  1  MPF reads in flight
- c1NotEmpty  in  1  MPF writes in flight
- rd_rsp_valid  in  1  c0Rx read response
- wr_rsp_valid  in  1  c1Rx write ack
- op_rd_valid  in  N_OPS  per-unit read request valid
- op_rd_addr  in  N_OPS*ADDR_W  per-unit read address
- op_rd_mdata  in  N_OPS*MDATA_W  per-unit read mdata
- op_wr_valid  in  N_OPS  per-unit write request valid
- op_wr_addr  in  N_OPS*ADDR_W  per-unit write address
- op_wr_data  in  N_OPS*DATA_W  per-unit write data
- op_wr_mdata  in  N_OPS*MDATA_W  per-unit write mdata
- op_active  out  N_OPS  is_active, one-hot or zero
- op_rd_ready  out  1  active unit may issue a read this cycle
- op_wr_ready  out  1  active unit may issue a write this cycle
- rd_valid, rd_addr, rd_mdata  out  1/ADDR_W/MDATA_W  registered c0 request
- wr_valid, wr_addr, wr_data, wr_mdata  out  1/ADDR_W/DATA_W/MDATA_W  registered c1 request
- cur_state  out  3  committed query state
- switching  out  1  high in DRAIN and SWITCH
- query_done  out  1  cur_state == 5
- cnt_err  out  1  sticky: response received with counter at 0

Behaviour:
- Reset values:
  - FSM = RUN, cur_state = 0, op_active = 'b01.
  - All valids, ready, switching, query_done and cnt_err = 0; counters = 0; data outputs = 0.
- FSM:
  - RUN: state_wr_en -> pending <= data; go to DRAIN next cycle. A write equal to cur_state still drains.
  - DRAIN: wait until rd_cnt == 0, wr_cnt == 0, !c0NotEmpty and !c1NotEmpty, all sampled the same cycle -> SWITCH. A state_wr_en here overwrites pending (last write wins).
  - SWITCH: exactly one cycle; cur_state <= pending (or state_wr_data if state_wr_en in this cycle); go to RUN.
- op_active:
  - Tracks cur_state and stays asserted through DRAIN so the old unit still receives its responses.
  - All zeros when cur_state >= N_OPS.
- Ready signals:
  - op_rd_ready = RUN && cur_state < N_OPS && !c0TxAlmFull && rd_cnt < MAX_OUT.
  - op_wr_ready uses c1TxAlmFull and wr_cnt in the same way.
  - Combinational from registered state and the AlmFull inputs.
- Issue:
  - A request from the active unit is accepted only when its valid and ready are both high in the same cycle.
  - Requests from inactive units, or presented while ready is low, are dropped; the unit must hold them.
  - rd_valid/rd_addr/rd_mdata register the accepted request; latency 1 cycle. Data outputs hold their last value when valid = 0. Writes are identical on c1.
- Counters:
  - +1 when an output valid is registered; -1 on the matching response.
  - Simultaneous +1/-1 leaves the count unchanged.
  - A -1 at 0 holds the counter at 0 and sets cnt_err.
- Reset mid-operation: asynchronous return to the reset values, including mid-DRAIN; pending is discarded.

Decomposition:
- Package op_tx_pkg:
  - OP_SCAN = 3'd0, OP_JOIN = 3'd1, OP_DONE = 3'd5.
  - Enum t_sw_state {RUN, DRAIN, SWITCH}.
  - Function for the outstanding counter width.
- Sub-module req_outstanding_ctr: up/down counter with underflow flag and at-max output; instantiated twice (rd, wr).

Test Plan:
- Reset release with op_rd_valid[0] = 1 and addr 0x100 -> rd_valid = 1, rd_addr = 0x100 one cycle later; op_active = 'b01; rd_cnt = 1.
- Issue 3 scan reads, then write 1 to state_wr_data -> switching = 1; op_rd_ready = 0; op_active stays 'b01 until 3 rd_rsp_valid pulses and c0NotEmpty low.
  -> Then SWITCH for 1 cycle, then op_active = 'b10 and cur_state = 1.
- Hold c0TxAlmFull = 1 in RUN with op_rd_valid[0] = 1 -> no rd_valid; release -> rd_valid the cycle after ready returns.
- In DRAIN, write 1 then 5 -> cur_state = 5, query_done = 1, op_active = 0, both readys 0.
- Same-cycle issue and rd_rsp_valid with rd_cnt = 2 -> rd_cnt stays 2.
- rd_rsp_valid with rd_cnt = 0 -> cnt_err = 1 and remains set.
- Assert reset mid-DRAIN -> FSM = RUN, cur_state = 0, counters = 0 immediately.
